updown_counter_169: RTL and testbench
=====================================

Name: updown_counter_169

Overview:
- Synchronous, cascadable, parameter-width up/down binary counter with parallel load and an auto-reload down mode.
- It is the down-counting counterpart of the team's 74x163-style up counter and keeps the same control idiom: CLR_L, LD_L, ENP, ENT, D, Q and RCO.
- Used for countdown timers and programmable dividers.
- Instances cascade by wiring RCO of the lower stage to ENT of the next stage.

Parameters:
W, 4, counter width in bits (W >= 2)

Ports:
CLK     in   1   clock; all state changes on rising edge
CLR_L   in   1   asynchronous active-low reset
LD_L    in   1   synchronous active-low parallel load
ENP     in   1   count enable, parallel (not propagated to RCO)
ENT     in   1   count enable, trickle (gates RCO)
UP      in   1   direction: 1 = count up, 0 = count down
ARL     in   1   auto-reload enable; affects down counting only
D       in   W   load value / reload value
Q       out  W   counter state
RCO     out  1   ripple carry/borrow, combinational
TCP     out  1   registered terminal-count pulse, one cycle wide

Behaviour:
- Reset: CLR_L=0 forces Q=0 and TCP=0 immediately, independent of CLK.
  - Reset held across an edge: that edge is ignored.
  - Release: counting resumes on the first rising edge after CLR_L goes high.
  - Reset mid-count: aborts the count, with no residual TCP.
- Priority at each rising edge (CLR_L=1):
  1. LD_L=0: Q<=D. Overrides ENP, ENT, UP and ARL. TCP<=0.
  2. Else if ENP=1 and ENT=1: count (see below).
  3. Else: hold Q; TCP<=0.
- Terminal state: TERM = (UP ? Q=={W{1}} : Q==0).
- Count up:
  - Q<=Q+1, modulo 2^W.
  - At all-ones Q wraps to 0 and TCP<=1.
- Count down, ARL=0:
  - Q<=Q-1, modulo 2^W.
  - At 0 Q wraps to all-ones and TCP<=1.
- Count down, ARL=1:
  - At Q=0, Q<=D (reload) and TCP<=1.
  - Otherwise Q<=Q-1.
  - Gives a divide-by-(D+1) period.
- TCP is 1 only in the single cycle following a terminal count edge. Otherwise it is 0.
- RCO = ENT & TERM, purely combinational.
  - Independent of ENP and LD_L.
  - A change on UP or ENT alters RCO in the same cycle.
- Direction change: UP is sampled at the edge. Changing UP between edges only affects RCO until the next edge.
- D=0 with ARL=1, down: Q stays 0, and TCP=1 every enabled cycle.
- Load and terminal coincide: the load wins and TCP stays 0.
- No X propagation: all outputs are defined from reset onward.

Test Plan:
1. Reset and load:
   - Stimulus: Q counting, assert CLR_L=0 between edges; then release, LD_L=0, D=4'hA for one edge.
   - Required: Q=0 immediately on reset (not at the next edge), TCP=0; after the load edge, Q=4'hA.
2. Up wrap:
   - Stimulus: load 4'hD, UP=1, ENP=ENT=1, 4 edges.
   - Required: Q sequence is D, E, F, 0, 1.
   - RCO=1 only while Q=F.
   - TCP=1 for exactly the cycle Q=0.
3. Down wrap with ARL=0:
   - Stimulus: load 4'h2, UP=0, 4 edges.
   - Required: Q sequence is 2, 1, 0, F, E.
   - RCO=1 while Q=0.
   - TCP=1 only while Q=F.
4. Auto-reload divider:
   - Stimulus: D=4'h3, load, then UP=0, ARL=1, 12 enabled edges.
   - Required: Q sequence is 3, 2, 1, 0, 3, 2, 1, 0, ...
   - TCP pulses exactly every 4th cycle, 3 pulses total.
5. Enable gating:
   - Stimulus: Q=0, UP=0.
   - ENP=0, ENT=1: Q holds and RCO=1.
   - ENP=1, ENT=0: Q holds and RCO=0.
   - Flip UP to 1 between edges: RCO falls to 0 in the same cycle.
6. Cascade:
   - Stimulus: two W=4 instances, lower RCO driving upper ENT, both loaded 8'h01, UP=0, 3 edges.
   - Required: combined value is 01, 00, FF, FE; the upper stage decrements only on the 00->FF edge.

Source files
------------

// File: rtl/updown_counter_169_if.sv
// Control/data bundle for the up/down counter: the controlling side drives the
// enables, direction, load and reload value; the counter returns state and carries.
interface updown_counter_169_if #(
    parameter int W = 4
);
    logic         LD_L;
    logic         ENP;
    logic         ENT;
    logic         UP;
    logic         ARL;
    logic [W-1:0] D;
    logic [W-1:0] Q;
    logic         RCO;
    logic         TCP;

    modport master (
        output LD_L, ENP, ENT, UP, ARL, D,
        input  Q, RCO, TCP
    );

    modport slave (
        input  LD_L, ENP, ENT, UP, ARL, D,
        output Q, RCO, TCP
    );
endinterface

// File: rtl/updown_counter_169.sv
// Cascadable W-bit up/down counter with parallel load, auto-reload down mode,
// combinational ripple carry/borrow and a registered terminal-count pulse.
module updown_counter_169 #(
    parameter int W = 4
) (
    input logic                 CLK,
    input logic                 CLR_L,
    updown_counter_169_if.slave bus
);
    logic [W-1:0] q;
    logic         tcp;
    logic         term;

    // Terminal state depends on the live direction so RCO follows UP between edges.
    assign term = bus.UP ? (q == {W{1'b1}}) : (q == {W{1'b0}});

    always_ff @(posedge CLK or negedge CLR_L) begin
        if (!CLR_L) begin
            q   <= '0;
            tcp <= 1'b0;
        end else if (!bus.LD_L) begin
            q   <= bus.D;
            tcp <= 1'b0;
        end else if (bus.ENP && bus.ENT) begin
            tcp <= term;
            if (bus.UP) begin
                q <= q + W'(1);
            end else if (bus.ARL && term) begin
                q <= bus.D;
            end else begin
                q <= q - W'(1);
            end
        end else begin
            tcp <= 1'b0;
        end
    end

    assign bus.Q   = q;
    assign bus.TCP = tcp;
    assign bus.RCO = bus.ENT & term;
endmodule

// File: tb/tb_updown_counter_169.sv
// Randomised bench for updown_counter_169: a two-stage cascade checked every cycle
// against an arithmetic reference model, plus literal expectations for key sequences.
module tb_updown_counter_169;
    localparam int W = 4;
    localparam int M = 1 << W;

    logic CLK = 1'b0;
    logic CLR_L;
    logic [W-1:0] hi_d;

    updown_counter_169_if #(.W(W)) if_lo ();
    updown_counter_169_if #(.W(W)) if_hi ();

    updown_counter_169 #(.W(W)) dut_lo (.CLK(CLK), .CLR_L(CLR_L), .bus(if_lo.slave));
    updown_counter_169 #(.W(W)) dut_hi (.CLK(CLK), .CLR_L(CLR_L), .bus(if_hi.slave));

    // Upper stage shares every control with the lower one except D; its ENT is the lower RCO.
    assign if_hi.LD_L = if_lo.LD_L;
    assign if_hi.ENP  = if_lo.ENP;
    assign if_hi.ENT  = if_lo.RCO;
    assign if_hi.UP   = if_lo.UP;
    assign if_hi.ARL  = 1'b0;
    assign if_hi.D    = hi_d;

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int mq    = 0;
    int mqh   = 0;
    bit mtcp  = 1'b0;
    bit mtcph = 1'b0;

    bit          lit_en = 1'b0;
    logic [W-1:0] lit_q;
    logic        lit_tcp;
    logic        lit_rco;
    logic        lit_hchk;
    logic [W-1:0] lit_hq;

    function automatic bit is_term(int q, bit up);
        return up ? (q == M - 1) : (q == 0);
    endfunction

    function automatic int next_q(int q, bit ld_l, bit enp, bit ent, bit up, bit arl, int d);
        if (!ld_l) return d;
        if (!(enp && ent)) return q;
        if (up) return (q + 1) % M;
        if (arl && q == 0) return d;
        return (q + M - 1) % M;
    endfunction

    function automatic bit next_tcp(int q, bit ld_l, bit enp, bit ent, bit up);
        if (!ld_l || !(enp && ent)) return 1'b0;
        return is_term(q, up);
    endfunction

    // Reference model: advances on each edge from the pre-edge model state and inputs.
    always @(posedge CLK or negedge CLR_L) begin
        if (!CLR_L) begin
            mq    <= 0;
            mqh   <= 0;
            mtcp  <= 1'b0;
            mtcph <= 1'b0;
        end else begin
            bit lo_rco;
            lo_rco = if_lo.ENT && is_term(mq, if_lo.UP);
            mq    <= next_q(mq, if_lo.LD_L, if_lo.ENP, if_lo.ENT, if_lo.UP, if_lo.ARL, int'(if_lo.D));
            mtcp  <= next_tcp(mq, if_lo.LD_L, if_lo.ENP, if_lo.ENT, if_lo.UP);
            mqh   <= next_q(mqh, if_lo.LD_L, if_lo.ENP, lo_rco, if_lo.UP, 1'b0, int'(hi_d));
            mtcph <= next_tcp(mqh, if_lo.LD_L, if_lo.ENP, lo_rco, if_lo.UP);
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Single compare process, sampling on the falling edge away from state changes.
    always @(negedge CLK) begin
        check_output("q_lo",   32'(if_lo.Q),   32'(mq));
        check_output("tcp_lo", 32'(if_lo.TCP), 32'(mtcp));
        check_output("rco_lo", 32'(if_lo.RCO), 32'(if_lo.ENT && is_term(mq, if_lo.UP)));
        check_output("q_hi",   32'(if_hi.Q),   32'(mqh));
        check_output("tcp_hi", 32'(if_hi.TCP), 32'(mtcph));
        check_output("rco_hi", 32'(if_hi.RCO), 32'(if_hi.ENT && is_term(mqh, if_hi.UP)));
        if (lit_en) begin
            check_output("lit_q",       32'(if_lo.Q),   32'(lit_q));
            check_output("lit_model_q", 32'(mq),        32'(lit_q));
            check_output("lit_tcp",     32'(if_lo.TCP), 32'(lit_tcp));
            check_output("lit_rco",     32'(if_lo.RCO), 32'(lit_rco));
            if (lit_hchk) begin
                check_output("lit_q_hi", 32'(if_hi.Q), 32'(lit_hq));
            end
        end
    end

    task automatic expect_lit(input logic [W-1:0] q, input logic tcp, input logic rco,
                              input logic hchk, input logic [W-1:0] hq);
        lit_q    = q;
        lit_tcp  = tcp;
        lit_rco  = rco;
        lit_hchk = hchk;
        lit_hq   = hq;
        lit_en   = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
        lit_en = 1'b0;
    endtask

    task automatic set_ctl(input logic ld_l, input logic enp, input logic ent,
                           input logic up, input logic arl, input logic [W-1:0] d);
        if_lo.LD_L = ld_l;
        if_lo.ENP  = enp;
        if_lo.ENT  = ent;
        if_lo.UP   = up;
        if_lo.ARL  = arl;
        if_lo.D    = d;
    endtask

    task automatic apply_stimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            CLR_L = ($urandom_range(0, 99) != 0);
            if_lo.LD_L = ($urandom_range(0, 11) != 0);
            if_lo.ENP  = ($urandom_range(0, 5) != 0);
            if_lo.ENT  = ($urandom_range(0, 5) != 0);
            if ($urandom_range(0, 15) == 0) if_lo.UP = ~if_lo.UP;
            if ($urandom_range(0, 7) == 0) if_lo.ARL = ~if_lo.ARL;
            if_lo.D = W'($urandom);
            hi_d    = W'($urandom);
            next_cycle();
        end
    endtask

    initial begin
        CLR_L = 1'b0;
        hi_d  = '0;
        set_ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        expect_lit(4'h0, 1'b0, 1'b0, 1'b1, 4'h0);
        next_cycle();
        CLR_L = 1'b1;
        next_cycle();

        // Count a little, then reset between edges and hold it across one edge.
        set_ctl(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h5);
        next_cycle();
        if_lo.LD_L = 1'b1;
        next_cycle();
        next_cycle();
        CLR_L = 1'b0;
        expect_lit(4'h0, 1'b0, 1'b0, 1'b1, 4'h0);
        next_cycle();
        expect_lit(4'h0, 1'b0, 1'b0, 1'b1, 4'h0);
        next_cycle();
        CLR_L = 1'b1;
        set_ctl(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'hA);
        expect_lit(4'h0, 1'b0, 1'b0, 1'b1, 4'h0);
        next_cycle();
        set_ctl(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'hA);
        expect_lit(4'hA, 1'b0, 1'b0, 1'b0, 4'h0);
        next_cycle();

        // Up wrap from D.
        set_ctl(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'hD);
        next_cycle();
        if_lo.LD_L = 1'b1;
        expect_lit(4'hD, 1'b0, 1'b0, 1'b0, 4'h0); next_cycle();
        expect_lit(4'hE, 1'b0, 1'b0, 1'b0, 4'h0); next_cycle();
        expect_lit(4'hF, 1'b0, 1'b1, 1'b0, 4'h0); next_cycle();
        expect_lit(4'h0, 1'b1, 1'b0, 1'b0, 4'h0); next_cycle();
        expect_lit(4'h1, 1'b0, 1'b0, 1'b0, 4'h0); next_cycle();

        // Down wrap without reload.
        set_ctl(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h2);
        next_cycle();
        if_lo.LD_L = 1'b1;
        expect_lit(4'h2, 1'b0, 1'b0, 1'b0, 4'h0); next_cycle();
        expect_lit(4'h1, 1'b0, 1'b0, 1'b0, 4'h0); next_cycle();
        expect_lit(4'h0, 1'b0, 1'b1, 1'b0, 4'h0); next_cycle();
        expect_lit(4'hF, 1'b1, 1'b0, 1'b0, 4'h0); next_cycle();
        expect_lit(4'hE, 1'b0, 1'b0, 1'b0, 4'h0); next_cycle();

        // Divide-by-4 auto-reload: 3,2,1,0 repeating, pulse on each reload.
        set_ctl(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'h3);
        next_cycle();
        if_lo.LD_L = 1'b1;
        for (int i = 0; i <= 12; i++) begin
            expect_lit(W'(3 - (i % 4)), (i > 0 && i % 4 == 0), (i % 4 == 3), 1'b0, 4'h0);
            next_cycle();
        end

        // Reload value of zero pins the counter at 0 with a pulse every enabled edge.
        set_ctl(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'h0);
        next_cycle();
        if_lo.LD_L = 1'b1;
        expect_lit(4'h0, 1'b0, 1'b1, 1'b0, 4'h0); next_cycle();
        expect_lit(4'h0, 1'b1, 1'b1, 1'b0, 4'h0); next_cycle();
        expect_lit(4'h0, 1'b1, 1'b1, 1'b0, 4'h0); next_cycle();

        // Load coinciding with a terminal count suppresses the pulse.
        set_ctl(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'h5);
        expect_lit(4'h0, 1'b1, 1'b1, 1'b0, 4'h0); next_cycle();
        set_ctl(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h5);
        expect_lit(4'h5, 1'b0, 1'b0, 1'b0, 4'h0); next_cycle();

        // Enable gating at Q=0 counting down, then a live direction flip.
        set_ctl(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        next_cycle();
        set_ctl(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        expect_lit(4'h0, 1'b0, 1'b1, 1'b0, 4'h0); next_cycle();
        expect_lit(4'h0, 1'b0, 1'b1, 1'b0, 4'h0); next_cycle();
        set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        expect_lit(4'h0, 1'b0, 1'b0, 1'b0, 4'h0); next_cycle();
        expect_lit(4'h0, 1'b0, 1'b0, 1'b0, 4'h0); next_cycle();
        set_ctl(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        expect_lit(4'h0, 1'b0, 1'b1, 1'b0, 4'h0); next_cycle();
        if_lo.UP = 1'b1;
        expect_lit(4'h0, 1'b0, 1'b0, 1'b0, 4'h0); next_cycle();

        // Cascade: combined 8-bit value 01 -> 00 -> FF -> FE.
        hi_d = 4'h0;
        set_ctl(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h1);
        next_cycle();
        if_lo.LD_L = 1'b1;
        expect_lit(4'h1, 1'b0, 1'b0, 1'b1, 4'h0); next_cycle();
        expect_lit(4'h0, 1'b0, 1'b1, 1'b1, 4'h0); next_cycle();
        expect_lit(4'hF, 1'b1, 1'b0, 1'b1, 4'hF); next_cycle();
        expect_lit(4'hE, 1'b0, 1'b0, 1'b1, 4'hF); next_cycle();

        apply_stimulus(3000);

        CLR_L = 1'b1;
        next_cycle();
        @(negedge CLK);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
